// File: rtl/tea_io_uart.sv
// UART on the 5-bit IO bus: TX FIFO + serializer, RX deserializer + FIFO, programmable baud divisor.
// Optional internal loopback (CTRL b0) is compiled in with `define TEA_UART_LOOPBACK_EN.
module tea_io_uart #(
    parameter logic [2:0] BASE_ADDR = 3'h0,
    parameter int         FIFO_AW   = 2,
    parameter logic [7:0] DIV_RESET = 8'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] io_addr,
    input  logic       io_rd,
    input  logic       io_wr,
    input  logic [7:0] io_wrdata,
    output logic [7:0] io_rddata,
    output logic       uart_txd,
    input  logic       uart_rxd,
    output logic       irq
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

    logic hit, wr_hit_q, wr_go, rd_data_hit, rd_stat_hit, rd_data_q, rd_stat_q, stat_clr;
    logic [7:0] div;
    logic loopback, rx_in;

    assign hit         = io_addr[4:2] == BASE_ADDR;
    assign wr_go       = io_wr && hit && !wr_hit_q;
    assign rd_data_hit = io_rd && hit && io_addr[1:0] == 2'd0;
    assign rd_stat_hit = io_rd && hit && io_addr[1:0] == 2'd1;
    assign stat_clr    = rd_stat_q && !rd_stat_hit;

    // ---------------- TX FIFO + serializer ----------------
    logic [7:0] tx_mem [DEPTH];
    logic [FIFO_AW:0] tx_wp, tx_rp;
    logic tx_full, tx_empty, tx_push, tx_pop, tx_tick, tx_bit_end;
    logic [1:0] tx_state;
    logic [7:0] tx_pre, tx_shift;
    logic [3:0] tx_tcnt;
    logic [2:0] tx_bcnt;

    assign tx_empty   = tx_wp == tx_rp;
    assign tx_full    = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                        (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
    assign tx_push    = wr_go && io_addr[1:0] == 2'd0 && !tx_full;
    assign tx_tick    = tx_pre == 8'd0;
    assign tx_bit_end = tx_tick && tx_tcnt == 4'd0;
    assign tx_pop     = !tx_empty && (tx_state == S_IDLE || (tx_state == S_STOP && tx_bit_end));

    always_ff @(posedge clk)
        if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= io_wrdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp <= '0; tx_rp <= '0; tx_pre <= '0; tx_tcnt <= '0;
            tx_state <= S_IDLE; tx_shift <= '0; tx_bcnt <= '0; uart_txd <= 1'b1;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            // A pop starts a new frame, so the bit timer restarts from a full period.
            if (tx_pop) begin
                tx_pre  <= div;
                tx_tcnt <= 4'd15;
            end else begin
                tx_pre <= tx_tick ? div : tx_pre - 8'd1;
                if (tx_tick) tx_tcnt <= tx_tcnt - 4'd1;
            end
            case (tx_state)
                S_IDLE: if (tx_pop) begin
                    tx_shift <= tx_mem[tx_rp[FIFO_AW-1:0]];
                    uart_txd <= 1'b0;
                    tx_state <= S_START;
                end
                S_START: if (tx_bit_end) begin
                    uart_txd <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    tx_bcnt  <= 3'd0;
                    tx_state <= S_DATA;
                end
                S_DATA: if (tx_bit_end) begin
                    if (tx_bcnt == 3'd7) begin
                        uart_txd <= 1'b1;
                        tx_state <= S_STOP;
                    end else begin
                        uart_txd <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bcnt  <= tx_bcnt + 3'd1;
                    end
                end
                default: if (tx_bit_end) begin
                    if (tx_pop) begin
                        tx_shift <= tx_mem[tx_rp[FIFO_AW-1:0]];
                        uart_txd <= 1'b0;
                        tx_state <= S_START;
                    end else begin
                        tx_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // ---------------- RX deserializer + FIFO ----------------
    logic [7:0] rx_mem [DEPTH];
    logic [FIFO_AW:0] rx_wp, rx_rp;
    logic rx_full, rx_empty, rx_push, rx_pop, rx_done, rx_tick, rx_samp, rx_s, rx_prev, rx_fall;
    logic [1:0] rx_sync, rx_state;
    logic [7:0] rx_pre, rx_shift;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bcnt;
    logic rx_ovr, frame_err;

`ifdef TEA_UART_LOOPBACK_EN
    assign rx_in = loopback ? uart_txd : uart_rxd;
`else
    assign rx_in    = uart_rxd;
    assign loopback = 1'b0;
`endif

    assign rx_s     = rx_sync[1];
    assign rx_fall  = rx_prev && !rx_s;
    assign rx_empty = rx_wp == rx_rp;
    assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                      (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);
    assign rx_tick  = rx_pre == 8'd0;
    // Start-bit check lands on tick 8 (mid-bit); the 4-bit counter then wraps to 15 for 16-tick spacing.
    assign rx_samp  = rx_tick && rx_tcnt == 4'd0;
    assign rx_done  = rx_state == S_STOP && rx_samp;
    assign rx_push  = rx_done && rx_s && !rx_full;
    assign rx_pop   = rd_data_q && !rd_data_hit && !rx_empty;
    assign irq      = !rx_empty;

    always_ff @(posedge clk)
        if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= 2'b11; rx_prev <= 1'b1; rx_wp <= '0; rx_rp <= '0;
            rx_pre <= '0; rx_tcnt <= '0; rx_state <= S_IDLE; rx_shift <= '0; rx_bcnt <= '0;
            rx_ovr <= 1'b0; frame_err <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], rx_in};
            rx_prev <= rx_s;
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
            if (rx_state == S_IDLE && rx_fall) begin
                rx_pre  <= div;
                rx_tcnt <= 4'd7;
            end else begin
                rx_pre <= rx_tick ? div : rx_pre - 8'd1;
                if (rx_tick) rx_tcnt <= rx_tcnt - 4'd1;
            end
            rx_ovr    <= (rx_done && rx_s && rx_full) || (rx_ovr && !stat_clr);
            frame_err <= (rx_done && !rx_s) || (frame_err && !stat_clr);
            case (rx_state)
                S_IDLE:  if (rx_fall) rx_state <= S_START;
                S_START: if (rx_samp) begin
                    rx_bcnt  <= 3'd0;
                    rx_state <= rx_s ? S_IDLE : S_DATA;
                end
                S_DATA: if (rx_samp) begin
                    rx_shift <= {rx_s, rx_shift[7:1]};
                    if (rx_bcnt == 3'd7) rx_state <= S_STOP;
                    else rx_bcnt <= rx_bcnt + 3'd1;
                end
                default: if (rx_samp) rx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- Register file ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_hit_q <= 1'b0; rd_data_q <= 1'b0; rd_stat_q <= 1'b0; div <= DIV_RESET;
        end else begin
            wr_hit_q  <= io_wr && hit;
            rd_data_q <= rd_data_hit;
            rd_stat_q <= rd_stat_hit;
            if (wr_go && io_addr[1:0] == 2'd2) div <= io_wrdata;
        end
    end

`ifdef TEA_UART_LOOPBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) loopback <= 1'b0;
        else if (wr_go && io_addr[1:0] == 2'd3) loopback <= io_wrdata[0];
    end
`endif

    always_comb begin
        io_rddata = 8'h00;
        if (io_rd && hit) begin
            case (io_addr[1:0])
                2'd0: io_rddata = rx_empty ? 8'h00 : rx_mem[rx_rp[FIFO_AW-1:0]];
                2'd1: io_rddata = {2'b00, tx_state != S_IDLE, frame_err, rx_ovr, !rx_empty, tx_empty, tx_full};
                2'd2: io_rddata = div;
                default: io_rddata = {7'd0, loopback};
            endcase
        end
    end
endmodule

// File: doc/tea_io_uart.md
Name: tea_io_uart

Overview:
- UART peripheral that responds on the CPU's 5-bit IO bus (io_addr/io_rd/io_wr/io_rddata/io_wrdata), selected by the CPU's io-prefixed load/store.
- Contains a TX FIFO with serializer and an RX deserializer with FIFO; baud rate is programmable.
- The CPU holds io_rd/io_wr for both phases of an instruction (2 clocks), so every access side effect happens exactly once per access.

Parameters:
- BASE_ADDR, 3'h0, block hit when io_addr[4:2]==BASE_ADDR; io_addr[1:0] selects the register.
- FIFO_AW, 2, log2 of TX and RX FIFO depth (4 entries each).
- DIV_RESET, 8'd0, reset value of the baud divisor register.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- io_addr  in  5  IO register address.
- io_rd  in  1  read strobe, held for 2 clocks per access.
- io_wr  in  1  write strobe, held for 2 clocks per access.
- io_wrdata  in  8  write data, stable while io_wr is high.
- io_rddata  out  8  read data, combinational.
- uart_txd  out  1  serial output, idle high.
- uart_rxd  in  1  serial input, asynchronous.
- irq  out  1  high while the RX FIFO is non-empty.

Behaviour:

Registers (offset = io_addr[1:0]):
- 0 DATA. Write pushes the TX FIFO. Read returns the RX FIFO head (8'h00 if empty).
- 1 STATUS (read-only):
  - b0 tx_full
  - b1 tx_empty
  - b2 rx_avail
  - b3 rx_overrun (sticky)
  - b4 frame_err (sticky)
  - b5 tx_busy
  - b7:6 = 0
- 2 DIV: read/write, 8 bits. One oversample tick every DIV+1 clocks; 16 ticks per bit.
- 3 CTRL: see Optional Feature.

IO bus:
- io_rddata = selected register when io_rd && hit, else 8'h00 (bus is OR-combinable).
- It stays stable across both cycles of a read.

Write and read side effects:
- Write action occurs at the clock edge ending the first cycle of a contiguous io_wr&&hit assertion, detected with a registered wr_hit_q.
- A write to DATA while tx_full is dropped silently.
- DATA read pop occurs at the first clock edge where a DATA-read hit seen last cycle is no longer present (registered rd_hit_q), i.e. after the CPU has captured the data.
- A STATUS read clears b3/b4 by the same end-of-read rule. A sticky event arriving on that same edge wins: the bit stays set.
- A simultaneous push and pop on the same FIFO are both performed; the count is unchanged.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: when the FIFO is non-empty, pop the head, restart the bit prescaler, go to START.
- uart_txd is registered and goes low on the edge 2 clocks after io_wr first rises with an empty FIFO.
- Each bit lasts exactly 16*(DIV+1) clocks. Data is sent LSB first, 8 bits, then 1 stop bit (high).
- STOP returns to IDLE, or to START directly if the FIFO is non-empty (back-to-back, no idle gap).
- tx_busy = state != IDLE.
- A DIV write mid-frame takes effect at the next tick reload.

RX path:
- uart_rxd passes through a 2-flop synchronizer, reset value 1.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a synchronized falling edge enters START.
  - START: at tick 8, if the line is still low go to DATA; otherwise return to IDLE (glitch rejected).
  - DATA: sample at every 16th tick thereafter, LSB first.
  - STOP: sample at mid-bit. If stop == 0, set frame_err and discard the byte. Else push to the RX FIFO; if the FIFO is full, set rx_overrun and drop the new byte (FIFO contents unchanged).
- After STOP sampling, the FSM returns to IDLE immediately so it can resync to the next start bit.

FIFOs:
- Pointers are FIFO_AW+1 bits and wrap modulo 2^(FIFO_AW+1).
- full = MSBs differ and low bits equal; empty = pointers equal.

Reset (async, rst_n low):
- uart_txd=1, irq=0, io_rddata=0.
- Both FSMs in IDLE, FIFOs empty, sticky bits 0, DIV=DIV_RESET, CTRL=0.
- A reset mid-frame aborts immediately; txd returns high in the same cycle (asynchronous).

Optional Feature:
- Macro: TEA_UART_LOOPBACK_EN.
- Defined: CTRL b0 = loopback (read/write, reset 0). When set, the RX synchronizer input is uart_txd instead of uart_rxd, and the uart_txd pin still drives normally. CTRL reads {7'b0, loopback}.
- Not defined: CTRL reads 8'h00, writes are ignored, RX always uses uart_rxd.

Test Plan:
1. Reset, then read STATUS -> 8'h02. Read DATA -> 8'h00. uart_txd=1, irq=0.
2. DIV=0; write DATA=8'hA5 (io_wr high 2 clocks) -> uart_txd frame: 16 clocks low, then bits 1,0,1,0,0,1,0,1 at 16 clocks each, then 16 clocks high. Exactly one byte sent (no double push).
3. Write 5 bytes with tx idle, DIV=0 -> first byte moves to the shifter, next 4 fill the FIFO, tx_full=1. A 6th write while full is dropped; exactly 5 frames are sent back-to-back.
4. Drive uart_rxd with 8'h3C at 16*(DIV+1) clocks/bit, DIV=3 -> irq=1, STATUS b2=1, DATA read returns 8'h3C across both read cycles. After the read, irq=0.
5. Send 5 RX bytes without reading -> STATUS b3=1 and the first 4 bytes are read back in order. A STATUS read clears b3. Then a frame with stop bit 0 -> b4=1 and no push.
6. With TEA_UART_LOOPBACK_EN: CTRL=1, write DATA=8'h81 -> 8'h81 is read back from DATA after about 160 clocks at DIV=0. Without the macro, a CTRL read returns 8'h00.
